// File: rtl/bd_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : bd_deserializer
// Description : Reassembles leaf-tagged serialized chunks into full-width
//               decoded BD words. A per-leaf table gives chunks per word.
// Revision    : 1.0 - initial release
// ============================================================================
module bd_deserializer #(
    parameter int                   NCODE       = 8,
    parameter int                   NDATA_IN    = 24,
    parameter int                   NBD_PAYLOAD = 64,
    parameter int                   NLEAF       = 16,
    parameter logic [2*NLEAF-1:0]   SER_TABLE   = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ser_in_v,
    input  logic [NCODE-1:0]        ser_in_code,
    input  logic [NDATA_IN-1:0]     ser_in_payload,
    output logic                    ser_in_a,
    output logic                    dec_out_v,
    output logic [NCODE-1:0]        dec_out_leaf_code,
    output logic [NBD_PAYLOAD-1:0]  dec_out_payload,
    input  logic                    dec_out_a,
    output logic                    err_code,
    output logic                    err_interleave
);

    localparam int c_MAX_SER = (NBD_PAYLOAD + NDATA_IN - 1) / NDATA_IN;
    localparam int c_CNT_W   = (c_MAX_SER > 1) ? $clog2(c_MAX_SER) : 1;
    localparam int c_LEAF_W  = (NLEAF > 1) ? $clog2(NLEAF) : 1;

    logic [c_CNT_W-1:0]     r_cnt;
    logic [NBD_PAYLOAD-1:0] r_acc;
    logic [NCODE-1:0]       r_held_code;

    logic [c_LEAF_W-1:0]    w_leaf;
    logic [1:0]             w_ser_field;
    logic                   w_invalid;
    logic                   w_restart;
    logic [c_CNT_W-1:0]     w_eff_cnt;
    logic                   w_final;
    logic                   w_accept;
    logic                   w_take;
    logic [NBD_PAYLOAD-1:0] w_chunk_shifted;
    logic [NBD_PAYLOAD-1:0] w_acc_next;

    // Classify the offered chunk and build the merged accumulator value.
    // Invalid codes are never final so they are always accepted and dropped.
    always_comb begin
        w_leaf          = ser_in_code[c_LEAF_W-1:0];
        w_ser_field     = SER_TABLE[2*w_leaf +: 2];
        w_invalid       = (ser_in_code >= NCODE'(NLEAF));
        w_restart       = (r_cnt != '0) && (ser_in_code != r_held_code);
        w_eff_cnt       = w_restart ? '0 : r_cnt;
        w_final         = !w_invalid && (32'(w_eff_cnt) == 32'(w_ser_field));
        ser_in_a        = !w_final || !dec_out_v || dec_out_a;
        w_accept        = ser_in_v && ser_in_a;
        w_take          = w_accept && !w_invalid;
        // Shift drops bits that fall above the output width (last chunk truncation).
        w_chunk_shifted = NBD_PAYLOAD'(ser_in_payload) << (32'(w_eff_cnt) * NDATA_IN);
        w_acc_next      = ((w_eff_cnt == '0) ? '0 : r_acc) | w_chunk_shifted;
    end

    // Partial-word state: chunk counter, accumulator and current word's code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_held_code <= '0;
        end else if (w_take) begin
            r_acc       <= w_acc_next;
            r_held_code <= ser_in_code;
            r_cnt       <= w_final ? '0 : w_eff_cnt + 1'b1;
        end
    end

    // Single-entry output register; a load in the same edge as a drain wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_out_v         <= 1'b0;
            dec_out_leaf_code <= '0;
            dec_out_payload   <= '0;
        end else if (w_take && w_final) begin
            dec_out_v         <= 1'b1;
            dec_out_leaf_code <= ser_in_code;
            dec_out_payload   <= w_acc_next;
        end else if (dec_out_a) begin
            dec_out_v         <= 1'b0;
        end
    end

    // One-cycle error pulses; a restart on an invalid code only flags err_code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_code       <= 1'b0;
            err_interleave <= 1'b0;
        end else begin
            err_code       <= w_accept && w_invalid;
            err_interleave <= w_take && w_restart;
        end
    end

    // Table entries beyond the maximum chunk count are unsupported.
    always_ff @(posedge clk) begin
        if (!reset && ser_in_v && !w_invalid)
            assert (32'(w_ser_field) <= c_MAX_SER - 1);
    end

endmodule
`default_nettype wire

// File: tb/tb_bd_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bd_deserializer
// Description : Directed self-checking bench for bd_deserializer.
//               Leaf table: 3 -> 1 chunk, 5 -> 3 chunks, 6 -> 2 chunks,
//               7 -> 1 chunk, all others 1 chunk.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bd_deserializer;

    logic        clk;
    logic        reset;
    logic        ser_in_v;
    logic [7:0]  ser_in_code;
    logic [23:0] ser_in_payload;
    logic        ser_in_a;
    logic        dec_out_v;
    logic [7:0]  dec_out_leaf_code;
    logic [63:0] dec_out_payload;
    logic        dec_out_a;
    logic        err_code;
    logic        err_interleave;

    int checks;
    int failures;

    bd_deserializer #(
        .NCODE       (8),
        .NDATA_IN    (24),
        .NBD_PAYLOAD (64),
        .NLEAF       (16),
        .SER_TABLE   (32'h0000_1800)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ser_in_v          (ser_in_v),
        .ser_in_code       (ser_in_code),
        .ser_in_payload    (ser_in_payload),
        .ser_in_a          (ser_in_a),
        .dec_out_v         (dec_out_v),
        .dec_out_leaf_code (dec_out_leaf_code),
        .dec_out_payload   (dec_out_payload),
        .dec_out_a         (dec_out_a),
        .err_code          (err_code),
        .err_interleave    (err_interleave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one chunk starting just after a rising edge; expects it accepted.
    task automatic chunk(input logic [7:0] c, input logic [23:0] p, input string nm);
        ser_in_v       = 1'b1;
        ser_in_code    = c;
        ser_in_payload = p;
        @(negedge clk);
        checks++;
        if (ser_in_a !== 1'b1) begin
            failures++;
            $display("FAIL %s ser_in_a got=%b exp=1", nm, ser_in_a);
        end
        @(posedge clk);
        #1;
        ser_in_v = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #2;
        checks++; if (dec_out_v !== 1'b0) begin failures++; $display("FAIL reset_v got=%b exp=0", dec_out_v); end
        checks++; if (dec_out_leaf_code !== 8'h00) begin failures++; $display("FAIL reset_code got=%h exp=00", dec_out_leaf_code); end
        checks++; if (dec_out_payload !== 64'h0) begin failures++; $display("FAIL reset_payload got=%h exp=0", dec_out_payload); end
        checks++; if (err_code !== 1'b0) begin failures++; $display("FAIL reset_err_code got=%b exp=0", err_code); end
        checks++; if (err_interleave !== 1'b0) begin failures++; $display("FAIL reset_err_il got=%b exp=0", err_interleave); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        dec_out_a = 1'b1;
        chunk(8'd3, 24'hABCDEF, "single");
        checks++; if (dec_out_v !== 1'b1) begin failures++; $display("FAIL single_v got=%b exp=1", dec_out_v); end
        checks++; if (dec_out_leaf_code !== 8'd3) begin failures++; $display("FAIL single_code got=%0d exp=3", dec_out_leaf_code); end
        checks++; if (dec_out_payload !== 64'h0000_0000_00AB_CDEF) begin failures++; $display("FAIL single_payload got=%h exp=0000000000abcdef", dec_out_payload); end
        @(posedge clk); #1;
        checks++; if (dec_out_v !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", dec_out_v); end
    endtask

    task automatic test_three_chunk;
        dec_out_a = 1'b1;
        chunk(8'd5, 24'h111111, "three_c0");
        checks++; if (dec_out_v !== 1'b0) begin failures++; $display("FAIL three_early0 got=%b exp=0", dec_out_v); end
        chunk(8'd5, 24'h222222, "three_c1");
        checks++; if (dec_out_v !== 1'b0) begin failures++; $display("FAIL three_early1 got=%b exp=0", dec_out_v); end
        chunk(8'd5, 24'h333333, "three_c2");
        checks++; if (dec_out_v !== 1'b1) begin failures++; $display("FAIL three_v got=%b exp=1", dec_out_v); end
        checks++; if (dec_out_leaf_code !== 8'd5) begin failures++; $display("FAIL three_code got=%0d exp=5", dec_out_leaf_code); end
        checks++; if (dec_out_payload !== 64'h3333_2222_2211_1111) begin failures++; $display("FAIL three_payload got=%h exp=3333222222111111", dec_out_payload); end
        @(posedge clk); #1;
        checks++; if (dec_out_v !== 1'b0) begin failures++; $display("FAIL three_drain got=%b exp=0", dec_out_v); end
    endtask

    task automatic test_backpressure;
        dec_out_a = 1'b0;
        chunk(8'd3, 24'h0000A1, "bp_first");
        ser_in_v       = 1'b1;
        ser_in_code    = 8'd3;
        ser_in_payload = 24'h0000B2;
        @(negedge clk);
        checks++; if (ser_in_a !== 1'b0) begin failures++; $display("FAIL bp_stall_a got=%b exp=0", ser_in_a); end
        @(posedge clk); #1;
        checks++; if (dec_out_v !== 1'b1) begin failures++; $display("FAIL bp_hold_v got=%b exp=1", dec_out_v); end
        checks++; if (dec_out_payload !== 64'hA1) begin failures++; $display("FAIL bp_hold_payload got=%h exp=a1", dec_out_payload); end
        dec_out_a = 1'b1;
        @(negedge clk);
        checks++; if (ser_in_a !== 1'b1) begin failures++; $display("FAIL bp_release_a got=%b exp=1", ser_in_a); end
        @(posedge clk); #1;
        ser_in_v = 1'b0;
        checks++; if (dec_out_v !== 1'b1) begin failures++; $display("FAIL bp_nobubble_v got=%b exp=1", dec_out_v); end
        checks++; if (dec_out_payload !== 64'hB2) begin failures++; $display("FAIL bp_second_payload got=%h exp=b2", dec_out_payload); end
        @(posedge clk); #1;
        checks++; if (dec_out_v !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", dec_out_v); end
    endtask

    task automatic test_interleave;
        dec_out_a = 1'b1;
        chunk(8'd6, 24'h555555, "il_c0");
        checks++; if (err_interleave !== 1'b0) begin failures++; $display("FAIL il_early_err got=%b exp=0", err_interleave); end
        chunk(8'd7, 24'h777777, "il_c7");
        checks++; if (err_interleave !== 1'b1) begin failures++; $display("FAIL il_pulse got=%b exp=1", err_interleave); end
        checks++; if (dec_out_v !== 1'b1) begin failures++; $display("FAIL il_v got=%b exp=1", dec_out_v); end
        checks++; if (dec_out_leaf_code !== 8'd7) begin failures++; $display("FAIL il_code got=%0d exp=7", dec_out_leaf_code); end
        checks++; if (dec_out_payload !== 64'h77_7777) begin failures++; $display("FAIL il_payload got=%h exp=777777", dec_out_payload); end
        @(posedge clk); #1;
        checks++; if (err_interleave !== 1'b0) begin failures++; $display("FAIL il_pulse_end got=%b exp=0", err_interleave); end
        checks++; if (dec_out_v !== 1'b0) begin failures++; $display("FAIL il_no_code6 got=%b exp=0", dec_out_v); end
    endtask

    task automatic test_invalid_code;
        dec_out_a = 1'b1;
        chunk(8'd6, 24'h0A0A0A, "inv_c0");
        chunk(8'd20, 24'hFFFFFF, "inv_bad");
        checks++; if (err_code !== 1'b1) begin failures++; $display("FAIL inv_pulse got=%b exp=1", err_code); end
        checks++; if (err_interleave !== 1'b0) begin failures++; $display("FAIL inv_no_il got=%b exp=0", err_interleave); end
        checks++; if (dec_out_v !== 1'b0) begin failures++; $display("FAIL inv_no_word got=%b exp=0", dec_out_v); end
        chunk(8'd6, 24'h0B0B0B, "inv_c1");
        checks++; if (err_code !== 1'b0) begin failures++; $display("FAIL inv_pulse_end got=%b exp=0", err_code); end
        checks++; if (dec_out_v !== 1'b1) begin failures++; $display("FAIL inv_v got=%b exp=1", dec_out_v); end
        checks++; if (dec_out_leaf_code !== 8'd6) begin failures++; $display("FAIL inv_code got=%0d exp=6", dec_out_leaf_code); end
        checks++; if (dec_out_payload !== 64'h0000_0B0B_0B0A_0A0A) begin failures++; $display("FAIL inv_payload got=%h exp=00000b0b0b0a0a0a", dec_out_payload); end
        @(posedge clk); #1;
        checks++; if (dec_out_v !== 1'b0) begin failures++; $display("FAIL inv_drain got=%b exp=0", dec_out_v); end
    endtask

    task automatic test_reset_mid_word;
        dec_out_a = 1'b1;
        chunk(8'd6, 24'h123456, "rst_c0");
        #1;
        reset = 1'b1;
        #1;
        checks++; if (dec_out_v !== 1'b0) begin failures++; $display("FAIL rst_v got=%b exp=0", dec_out_v); end
        checks++; if (dec_out_payload !== 64'h0) begin failures++; $display("FAIL rst_payload got=%h exp=0", dec_out_payload); end
        checks++; if (err_code !== 1'b0 || err_interleave !== 1'b0) begin failures++; $display("FAIL rst_errs got=%b%b exp=00", err_code, err_interleave); end
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chunk(8'd6, 24'h654321, "rst_new_c0");
        checks++; if (dec_out_v !== 1'b0) begin failures++; $display("FAIL rst_no_complete got=%b exp=0", dec_out_v); end
        chunk(8'd6, 24'h000001, "rst_new_c1");
        checks++; if (err_interleave !== 1'b0) begin failures++; $display("FAIL rst_no_il got=%b exp=0", err_interleave); end
        checks++; if (dec_out_v !== 1'b1) begin failures++; $display("FAIL rst_word_v got=%b exp=1", dec_out_v); end
        checks++; if (dec_out_payload !== 64'h0000_0000_0165_4321) begin failures++; $display("FAIL rst_word_payload got=%h exp=0000000001654321", dec_out_payload); end
        @(posedge clk); #1;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        ser_in_v       = 1'b0;
        ser_in_code    = 8'd0;
        ser_in_payload = 24'd0;
        dec_out_a      = 1'b0;
        reset          = 1'b0;
        test_reset();
        test_single();
        test_three_chunk();
        test_backpressure();
        test_interleave();
        test_invalid_code();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
